rr_dff_arbiter: RTL and testbench

- Round-robin arbiter that shares one W-bit D-flip-flop storage register between N requesters.
- Each cycle, at most one requester owns the register. The owner's data is captured on the rising clock edge, as a DFF would capture it.
- A hold limit prevents one requester from monopolising the register while others wait.
- Sits between multiple producer blocks and the shared sequential storage element in the practice datapath.

---
 rtl/rr_dff_arbiter.sv | 134 +++++++++++++
 tb/tb_rr_dff_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_dff_arbiter.sv
// Round-robin arbiter sharing one W-bit storage register between N requesters.
// Owner is held up to MAX_HOLD writes while another requester is pending.
module rr_dff_arbiter #(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int MAX_HOLD = 4,
  parameter int IW       = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] wdata,
  output logic [N-1:0]   gnt,
  output logic [W-1:0]   q,
  output logic [IW-1:0]  q_owner,
  output logic           q_valid
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t        r_state, w_state_n;
  logic [IW-1:0] r_owner, w_owner_n;
  logic [IW-1:0] r_ptr, w_ptr_n;
  logic [HW-1:0] r_hold, w_hold_n;
  logic [W-1:0]  r_q;
  logic [IW-1:0] r_q_owner;
  logic          r_q_valid;

  logic [N-1:0]  w_own_oh;
  logic [IW-1:0] w_start;
  logic [IW-1:0] w_idx;
  logic [IW-1:0] w_win;
  logic          w_found;
  logic          w_other;
  logic          w_wr;
  logic          w_rel;
  logic [W-1:0]  w_wsel;

  assign w_own_oh = N'(1) << r_owner;
  assign w_other  = |(req & ~w_own_oh);
  assign w_wr     = (r_state == S_HOLD) && req[r_owner];
  assign w_rel    = (r_state == S_HOLD) &&
                    (!req[r_owner] ||
                     ((r_hold == HOLD_LAST) && w_other));
  assign w_wsel   = wdata[int'(r_owner)*W +: W];

  // On release the search starts just past the owner, giving it last priority.
  assign w_start = (r_state == S_HOLD) ? r_owner + 1'b1 : r_ptr;

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = w_start + IW'(k);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_n;
      r_owner <= w_owner_n;
      r_ptr   <= w_ptr_n;
      r_hold  <= w_hold_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_owner_n = r_owner;
    w_ptr_n   = r_ptr;
    w_hold_n  = r_hold;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_n = S_HOLD;
          w_owner_n = w_win;
          w_hold_n  = '0;
        end
      end
      S_HOLD: begin
        if (w_rel) begin
          w_ptr_n  = r_owner + 1'b1;
          w_hold_n = '0;
          if (w_found) begin
            w_owner_n = w_win;
          end else begin
            w_state_n = S_IDLE;
          end
        end else if (w_wr && (r_hold != HOLD_LAST)) begin
          w_hold_n = r_hold + 1'b1;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_comb begin
    gnt = '0;
    if (r_state == S_HOLD) begin
      gnt = w_own_oh;
    end
  end

  // Forced release still writes; a drop never does since req[owner] is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q       <= '0;
      r_q_owner <= '0;
      r_q_valid <= 1'b0;
    end else if (w_wr) begin
      r_q       <= w_wsel;
      r_q_owner <= r_owner;
      r_q_valid <= 1'b1;
    end
  end

  assign q       = r_q;
  assign q_owner = r_q_owner;
  assign q_valid = r_q_valid;

endmodule

// File: tb/tb_rr_dff_arbiter.sv
// Self-checking bench for rr_dff_arbiter: directed scenarios plus
// randomized traffic against a tenure-counting reference model.
module tb_rr_dff_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MH = 4;
  localparam int IW = 2;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   gnt;
  logic [W-1:0]   q;
  logic [IW-1:0]  q_owner;
  logic           q_valid;

  int n_cmp;
  int n_bad;

  rr_dff_arbiter #(.N(N), .W(W), .MAX_HOLD(MH), .IW(IW)) dut (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata),
    .gnt(gnt), .q(q), .q_owner(q_owner), .q_valid(q_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: owner = -1 when idle; writes = writes in this tenure.
  int           m_own;
  int           m_ptr;
  int           m_writes;
  logic [W-1:0] m_q;
  int           m_qo;
  bit           m_qv;
  bit           m_rel;
  bit           m_others;
  int           m_start;
  int           m_o;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_own = -1; m_ptr = 0; m_writes = 0;
      m_q = '0; m_qo = 0; m_qv = 1'b0;
    end else begin
      m_rel = 1'b1;
      m_start = m_ptr;
      if (m_own >= 0) begin
        m_o = m_own;
        m_others = (req & ~(N'(1) << m_o)) != 0;
        if (req[m_o]) begin
          m_q = wdata[m_o*W +: W];
          m_qo = m_o; m_qv = 1'b1;
          m_writes = m_writes + 1;
        end
        m_rel = !req[m_o] || (m_others && m_writes >= MH);
        if (m_rel) begin
          m_ptr = (m_o + 1) % N;
          m_start = m_ptr;
        end
      end
      if (m_rel) begin
        m_own = -1;
        for (int k = 0; k < N; k++) begin
          if (m_own < 0 && req[(m_start + k) % N]) begin
            m_own = (m_start + k) % N;
            m_writes = 0;
          end
        end
      end
    end
  end

  function automatic logic [N-1:0] m_gnt();
    return (m_own < 0) ? '0 : (N'(1) << m_own);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wd(input int i, input logic [W-1:0] v);
    wdata[i*W +: W] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (gnt !== 4'b0000 || q !== 8'h00 || q_owner !== 2'd0 ||
        q_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: gnt=%b q=%h own=%0d v=%b want 0", gnt, q,
               q_owner, q_valid);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 4'b0100; set_wd(2, 8'h3C);
    cyc(); cyc();
    n_cmp++;
    if (gnt !== 4'b0100 || q !== 8'h3C) begin
      n_bad++;
      $display("FAIL async_pre: gnt=%b q=%h want 0100/3c", gnt, q);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (gnt !== 4'b0000 || q !== 8'h00 || q_owner !== 2'd0 ||
        q_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: gnt=%b q=%h own=%0d v=%b want 0",
               gnt, q, q_owner, q_valid);
    end
    #1 rst = 1'b0; req = '0;
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0010; set_wd(1, 8'hA5);
    cyc();
    n_cmp++;
    if (gnt !== 4'b0010 || q_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_gnt: gnt=%b v=%b want 0010/0", gnt, q_valid);
    end
    cyc();
    n_cmp++;
    if (q !== 8'hA5 || q_owner !== 2'd1 || q_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL single_wr: q=%h own=%0d v=%b want a5/1/1", q,
               q_owner, q_valid);
    end
    for (int c = 0; c < 10; c++) begin
      cyc();
      n_cmp++;
      if (gnt !== 4'b0010) begin
        n_bad++;
        $display("FAIL single_hold c%0d: gnt=%b want 0010", c, gnt);
      end
    end
  endtask

  task automatic test_contention();
    int e;
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < N; i++) set_wd(i, W'(8'h10 + i));
    for (int c = 0; c < 20; c++) begin
      cyc();
      n_cmp++;
      if (gnt !== (N'(1) << ((c / MH) % N))) begin
        n_bad++;
        $display("FAIL cont_gnt c%0d: gnt=%b want %b", c, gnt,
                 N'(1) << ((c / MH) % N));
      end
      if (c >= 1) begin
        e = ((c - 1) / MH) % N;
        n_cmp++;
        if (q !== W'(8'h10 + e) || q_owner !== IW'(e) || !q_valid) begin
          n_bad++;
          $display("FAIL cont_q c%0d: q=%h own=%0d want %h/%0d", c, q,
                   q_owner, 8'h10 + e, e);
        end
      end
    end
  endtask

  task automatic test_early_drop();
    do_reset();
    req = 4'b0101; set_wd(0, 8'h20); set_wd(2, 8'h40);
    cyc(); cyc();
    set_wd(0, 8'h21);
    cyc();
    req = 4'b0100;
    cyc();
    n_cmp++;
    if (gnt !== 4'b0100 || q !== 8'h21 || q_owner !== 2'd0) begin
      n_bad++;
      $display("FAIL drop_sw: gnt=%b q=%h own=%0d want 0100/21/0", gnt,
               q, q_owner);
    end
    cyc();
    n_cmp++;
    if (q !== 8'h40 || q_owner !== 2'd2) begin
      n_bad++;
      $display("FAIL drop_wr: q=%h own=%0d want 40/2", q, q_owner);
    end
  endtask

  task automatic test_idle_return();
    do_reset();
    req = 4'b1000; set_wd(3, 8'h77);
    cyc(); cyc();
    req = 4'b0000;
    cyc(); cyc();
    n_cmp++;
    if (gnt !== 4'b0000 || q !== 8'h77 || q_owner !== 2'd3 ||
        q_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL idle_keep: gnt=%b q=%h own=%0d v=%b want 0/77/3/1",
               gnt, q, q_owner, q_valid);
    end
    req = 4'b1001;
    cyc();
    n_cmp++;
    if (gnt !== 4'b0001) begin
      n_bad++;
      $display("FAIL idle_ptr: gnt=%b want 0001", gnt);
    end
  endtask

  task automatic test_late_arrival();
    do_reset();
    req = 4'b0010; set_wd(1, 8'h55); set_wd(2, 8'h99);
    repeat (MH) cyc();
    n_cmp++;
    if (gnt !== 4'b0010) begin
      n_bad++;
      $display("FAIL late_pre: gnt=%b want 0010", gnt);
    end
    req = 4'b0110; set_wd(1, 8'h56);
    cyc();
    n_cmp++;
    if (gnt !== 4'b0100 || q !== 8'h56 || q_owner !== 2'd1) begin
      n_bad++;
      $display("FAIL late_sw: gnt=%b q=%h own=%0d want 0100/56/1", gnt,
               q, q_owner);
    end
    cyc();
    n_cmp++;
    if (q !== 8'h99 || q_owner !== 2'd2) begin
      n_bad++;
      $display("FAIL late_wr: q=%h own=%0d want 99/2", q, q_owner);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) < 3) req = N'($urandom_range(0, 15));
      wdata = (N*W)'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      cyc();
      rst = 1'b0;
      n_cmp++;
      if (gnt !== m_gnt() || q !== m_q || q_owner !== IW'(m_qo) ||
          q_valid !== m_qv) begin
        n_bad++;
        $display("FAIL rand c%0d: gnt=%b q=%h own=%0d v=%b want %b/%h/%0d/%b",
                 c, gnt, q, q_owner, q_valid, m_gnt(), m_q, m_qo, m_qv);
      end
      n_cmp++;
      if (!$onehot0(gnt)) begin
        n_bad++;
        $display("FAIL rand_onehot c%0d: gnt=%b want one-hot/zero", c, gnt);
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b1; req = '0; wdata = '0;
    test_reset();
    test_async_reset();
    test_single();
    test_contention();
    test_early_drop();
    test_idle_return();
    test_late_arrival();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
